// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MBR fetch path: wait-stated read/write access to a
// resettable word array with a valid/ready response and a side preload port.
module mem_responder #(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              req_ready,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    input  logic              rsp_ready,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_err
);

    localparam int unsigned Depth    = 2 ** ADDR_W;
    localparam logic [3:0]  WaitLast = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StResp
    } state_e;

    state_e            state_q;
    logic [3:0]        wait_cnt_q;
    logic              write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mem_q [Depth];

    // A preload in the same cycle takes priority over a request.
    always_comb begin
        req_ready = (state_q == StIdle) && !load_en && !reset;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            write_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rsp_valid  <= 1'b0;
            rsp_data   <= '0;
            load_err   <= 1'b0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            load_err <= load_en && (state_q != StIdle);
            unique case (state_q)
                StIdle: begin
                    if (load_en) begin
                        mem_q[load_addr] <= load_data;
                    end else if (req_valid) begin
                        addr_q     <= req_addr;
                        write_q    <= req_write;
                        wdata_q    <= req_wdata;
                        wait_cnt_q <= '0;
                        state_q    <= StWait;
                    end
                end
                // The counter runs 0..WAIT_STATES so the response lands WAIT_STATES+1
                // edges after acceptance, including the zero-wait build.
                StWait: begin
                    if (wait_cnt_q == WaitLast) begin
                        state_q   <= StResp;
                        rsp_valid <= 1'b1;
                        if (write_q) begin
                            mem_q[addr_q] <= wdata_q;
                            rsp_data      <= wdata_q;
                        end else begin
                            rsp_data <= mem_q[addr_q];
                        end
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 4'd1;
                    end
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
